// File: rtl/softusb_iotest.sv
// softusb_iotest: IO-bus test/debug peripheral for the navre core.
// Provides a byte trace FIFO drained over a valid/ready stream, pass/fail
// end-of-test signalling, a synchronised input port and a scratch register.
// io_di is registered and forced to zero when not selected so several
// peripherals can be OR-ed onto the core's read bus.
module softusb_iotest #(
   parameter logic [5:0] base_addr       = 6'h00,
   parameter int         fifo_depth_log2 = 4,
   parameter logic [7:0] end_pass        = 8'hFE,
   parameter logic [7:0] end_fail        = 8'hFF
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       io_re,
   input  logic       io_we,
   input  logic [5:0] io_a,
   input  logic [7:0] io_do,
   output logic [7:0] io_di,
   input  logic [7:0] in_pins,
   output logic       trace_valid,
   input  logic       trace_ready,
   output logic [7:0] trace_data,
   output logic       end_of_test,
   output logic       test_done,
   output logic       test_fail,
   output logic       irq
);

   localparam int DEPTH = 1 << fifo_depth_log2;
   localparam int LW    = fifo_depth_log2 + 1;

   // Register offsets inside the 8-byte window
   localparam logic [2:0] OFF_CTRL    = 3'd0;
   localparam logic [2:0] OFF_TXDATA  = 3'd1;
   localparam logic [2:0] OFF_STATUS  = 3'd2;
   localparam logic [2:0] OFF_INPUT   = 3'd3;
   localparam logic [2:0] OFF_SCRATCH = 3'd4;
   localparam logic [2:0] OFF_CLEAR   = 3'd5;

   // Address decode
   logic       sel;
   logic [2:0] off;
   logic       wr_sel;
   logic       rd_sel;

   assign sel    = (io_a[5:3] == base_addr[5:3]);
   assign off    = io_a[2:0];
   assign wr_sel = io_we & sel;
   assign rd_sel = io_re & sel;

   // FIFO state
   logic [7:0]                 mem [DEPTH];
   logic [fifo_depth_log2-1:0] rd_ptr;
   logic [fifo_depth_log2-1:0] wr_ptr;
   logic [LW-1:0]              level;
   logic                       overflow;
   logic                       full;
   logic                       empty;
   logic                       pop;
   logic                       push_req;
   logic                       push_ok;
   logic                       clear;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign pop      = trace_valid & trace_ready;
   assign push_req = wr_sel & (off == OFF_TXDATA);
   // A full FIFO still takes a byte when the head leaves in the same cycle
   assign push_ok  = push_req & (~full | pop);
   assign clear    = wr_sel & (off == OFF_CLEAR);

   assign trace_valid = ~empty;
   assign trace_data  = mem[rd_ptr];
   assign irq         = overflow;

   // Level is reported in 5 bits; a 32-deep FIFO saturates at 31 when full
   logic [5:0] lvl6;
   logic [4:0] level5;

   assign lvl6   = 6'(level);
   assign level5 = lvl6[5] ? 5'h1F : lvl6[4:0];

   // Other registers
   logic [7:0] scratch;
   logic [7:0] sync1;
   logic [7:0] sync2;
   logic [7:0] rdata;

   // FIFO pointers, level and sticky overflow; a flush beats any pop
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_req & ~push_ok)
            overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // FIFO storage; contents are meaningless once the pointers reset
   always_ff @(posedge sys_clk) begin
      if (push_ok)
         mem[wr_ptr] <= io_do;
   end

   // End-of-test flags: sticky done/fail plus a one-cycle pulse per end write
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         end_of_test <= 1'b0;
         test_done   <= 1'b0;
         test_fail   <= 1'b0;
      end else begin
         end_of_test <= 1'b0;
         if (wr_sel && off == OFF_CTRL) begin
            if (io_do == end_fail) begin
               end_of_test <= 1'b1;
               test_done   <= 1'b1;
               test_fail   <= 1'b1;
            end else if (io_do == end_pass) begin
               end_of_test <= 1'b1;
               test_done   <= 1'b1;
               test_fail   <= 1'b0;
            end
         end
      end
   end

   // Scratch register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         scratch <= 8'h00;
      else if (wr_sel && off == OFF_SCRATCH)
         scratch <= io_do;
   end

   // Two-flop synchroniser for the asynchronous input pins
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= in_pins;
         sync2 <= sync1;
      end
   end

   // Read mux over pre-update state, so a STATUS read beside a push/pop
   // reports the level before that transfer
   always_comb begin
      rdata = 8'h00;
      case (off)
         OFF_CTRL:    rdata = {6'b0, test_fail, test_done};
         OFF_STATUS:  rdata = {overflow, full, empty, level5};
         OFF_INPUT:   rdata = sync2;
         OFF_SCRATCH: rdata = scratch;
         default:     rdata = 8'h00;
      endcase
   end

   // Registered read data, zero whenever this block is not being read
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         io_di <= 8'h00;
      else
         io_di <= rd_sel ? rdata : 8'h00;
   end

endmodule

// File: tb/tb_softusb_iotest.sv
// Directed bench for softusb_iotest: register map, trace FIFO, end-of-test
// signalling, input synchroniser and asynchronous reset.
module tb_softusb_iotest;

   localparam logic [5:0] BASE = 6'h00;
   localparam logic [5:0] A_CTRL = BASE + 6'd0;
   localparam logic [5:0] A_TX   = BASE + 6'd1;
   localparam logic [5:0] A_STAT = BASE + 6'd2;
   localparam logic [5:0] A_IN   = BASE + 6'd3;
   localparam logic [5:0] A_SCR  = BASE + 6'd4;
   localparam logic [5:0] A_CLR  = BASE + 6'd5;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       io_re = 1'b0;
   logic       io_we = 1'b0;
   logic [5:0] io_a = 6'h00;
   logic [7:0] io_do = 8'h00;
   logic [7:0] io_di;
   logic [7:0] in_pins = 8'h00;
   logic       trace_valid;
   logic       trace_ready = 1'b0;
   logic [7:0] trace_data;
   logic       end_of_test;
   logic       test_done;
   logic       test_fail;
   logic       irq;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] rd;

   softusb_iotest #(
      .base_addr(BASE), .fifo_depth_log2(4), .end_pass(8'hFE), .end_fail(8'hFF)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .io_re(io_re), .io_we(io_we),
      .io_a(io_a), .io_do(io_do), .io_di(io_di), .in_pins(in_pins),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
      .end_of_test(end_of_test), .test_done(test_done), .test_fail(test_fail),
      .irq(irq)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One write strobe, returns 1 ns after the capturing edge
   task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
      io_we = 1'b1; io_a = a; io_do = d;
      @(posedge sys_clk); #1;
      io_we = 1'b0;
   endtask

   // One read strobe; io_di is registered, so it is valid after the edge
   task automatic io_rd(input logic [5:0] a, output logic [7:0] d);
      io_re = 1'b1; io_a = a;
      @(posedge sys_clk); #1;
      io_re = 1'b0;
      d = io_di;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      chk("rst_outs", {2'b0, io_di, trace_valid, end_of_test, test_done, test_fail, irq},
          16'h0000);
      @(posedge sys_clk); @(posedge sys_clk); #1;
      sys_rst = 1'b0;

      io_rd(A_STAT, rd);
      chk("status_reset", rd, 16'h0020);
      @(posedge sys_clk); #1;
      chk("io_di_idle", io_di, 16'h0000);

      // Overfill with stream stalled: 17 pushes, last is dropped
      for (int i = 0; i < 17; i++) io_wr(A_TX, 8'(i));
      io_rd(A_STAT, rd);
      chk("status_ovf", rd, 16'h00D0);
      chk("irq_ovf", irq, 16'h1);
      trace_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d", i), {trace_valid, trace_data}, {7'b0, 1'b1, 8'(i)});
         @(posedge sys_clk); #1;
      end
      chk("drain_empty", trace_valid, 16'h0);
      trace_ready = 1'b0;
      io_wr(A_CLR, 8'h00);
      chk("irq_clr1", irq, 16'h0);

      // Push into a full FIFO in the same cycle as a pop
      for (int i = 0; i < 16; i++) io_wr(A_TX, 8'h20 + 8'(i));
      trace_ready = 1'b1;
      io_wr(A_TX, 8'hAA);
      trace_ready = 1'b0;
      io_rd(A_STAT, rd);
      chk("status_full_pp", rd, 16'h0050);
      chk("irq_pp", irq, 16'h0);
      trace_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("pp%0d", i), {trace_valid, trace_data},
             {7'b0, 1'b1, (i == 15) ? 8'hAA : 8'h21 + 8'(i)});
         @(posedge sys_clk); #1;
      end
      chk("pp_empty", trace_valid, 16'h0);
      trace_ready = 1'b0;

      // End-of-test signalling
      io_wr(A_CTRL, 8'hFE);
      chk("eot_pass_hi", end_of_test, 16'h1);
      @(posedge sys_clk); #1;
      chk("eot_pass_lo", end_of_test, 16'h0);
      io_rd(A_CTRL, rd);
      chk("ctrl_pass", rd, 16'h0001);
      io_wr(A_CTRL, 8'hFF);
      chk("eot_fail_hi", end_of_test, 16'h1);
      @(posedge sys_clk); #1;
      chk("eot_fail_lo", end_of_test, 16'h0);
      io_rd(A_CTRL, rd);
      chk("ctrl_fail", rd, 16'h0003);
      io_wr(A_CTRL, 8'h12);
      chk("eot_other", end_of_test, 16'h0);
      io_rd(A_CTRL, rd);
      chk("ctrl_other", rd, 16'h0003);
      chk("done_fail_pins", {test_done, test_fail}, 16'h3);

      // Input synchroniser latency: read at t sees old value, at t+3 new
      in_pins = 8'h5A;
      io_rd(A_IN, rd);
      chk("input_t0", rd, 16'h0000);
      @(posedge sys_clk); #1;
      io_rd(A_IN, rd);
      chk("input_t3", rd, 16'h005A);

      // Scratch and out-of-window strobes
      io_wr(A_SCR, 8'h3C);
      io_rd(A_SCR, rd);
      chk("scratch", rd, 16'h003C);
      io_wr(BASE + 6'd12, 8'h77);
      io_wr(BASE + 6'd8, 8'hFE);
      chk("oow_no_eot", end_of_test, 16'h0);
      io_rd(BASE + 6'd12, rd);
      chk("oow_read", rd, 16'h0000);
      io_rd(A_SCR, rd);
      chk("scratch_kept", rd, 16'h003C);

      // Flush with overflow set and 5 bytes queued
      for (int i = 0; i < 17; i++) io_wr(A_TX, 8'h40 + 8'(i));
      trace_ready = 1'b1;
      repeat (11) @(posedge sys_clk);
      #1;
      trace_ready = 1'b0;
      io_rd(A_STAT, rd);
      chk("status_5ovf", rd, 16'h0085);
      chk("irq_5ovf", irq, 16'h1);
      io_wr(A_CLR, 8'h99);
      io_rd(A_STAT, rd);
      chk("status_clr", rd, 16'h0020);
      chk("irq_clr2", irq, 16'h0);
      chk("done_after_clr", {test_done, test_fail}, 16'h3);

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 3; i++) io_wr(A_TX, 8'h60 + 8'(i));
      trace_ready = 1'b1;
      io_rd(A_SCR, rd);
      chk("pre_rst", {io_di, trace_valid, 7'b0}, {8'h3C, 1'b1, 7'b0});
      #2 sys_rst = 1'b1;
      #1;
      chk("async_rst", {2'b0, io_di, trace_valid, end_of_test, test_done, test_fail, irq},
          16'h0000);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      trace_ready = 1'b0;
      io_rd(A_STAT, rd);
      chk("status_post_rst", rd, 16'h0020);
      io_rd(A_SCR, rd);
      chk("scratch_post_rst", rd, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/softusb_iotest.md
Name: softusb_iotest

Overview:
- IO-bus test/debug peripheral for the softusb navre core.
- Sits on the core's 6-bit IO bus at a parametrised base address.
- Provides a byte trace FIFO drained by a valid/ready stream, end-of-test and pass/fail signalling, a synchronised input port and a scratch register.
- Synthesisable: used in simulation benches to detect test completion, and in hardware as a trace tap.

Parameters:
- base_addr, 6'h00, IO address of register 0; must be a multiple of 8; window is base_addr..base_addr+7.
- fifo_depth_log2, 4, trace FIFO depth = 2**fifo_depth_log2 bytes; legal range 1..5.
- end_pass, 8'hFE, CTRL write value meaning "test passed".
- end_fail, 8'hFF, CTRL write value meaning "test failed".

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous, active-high reset.
- io_re  in  1  IO read strobe from core.
- io_we  in  1  IO write strobe from core.
- io_a  in  6  IO address.
- io_do  in  8  write data from core.
- io_di  out  8  read data to core; registered; 0 when not selected, so it is OR-combinable.
- in_pins  in  8  asynchronous external inputs.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts the head byte.
- trace_data  out  8  FIFO head byte.
- end_of_test  out  1  one-cycle pulse on any pass/fail CTRL write.
- test_done  out  1  sticky: a pass/fail write has occurred.
- test_fail  out  1  sticky: last end write was end_fail.
- irq  out  1  equals the overflow sticky bit.

Behaviour:
- Reset (async) values: io_di=0, FIFO empty, trace_valid=0, end_of_test=0, test_done=0, test_fail=0, overflow=0, scratch=0, sync flops=0, irq=0.
- Select: sel = (io_a[5:3] == base_addr[5:3]); offset = io_a[2:0]. Strobes outside the window are ignored.
- Read latency: io_di is valid the cycle after io_re. In cycles without a selected io_re, io_di=0 on the next edge.
- Register map (offset, read / write):
  - 0 CTRL: read {6'b0, test_fail, test_done}. Write end_pass: done=1, fail=0, pulse end_of_test. Write end_fail: done=1, fail=1, pulse. Any other value: no effect.
  - 1 TXDATA: read 0. Write pushes io_do into the FIFO.
  - 2 STATUS: read {overflow, full, empty, level[4:0]}; level is 0..depth, held in a (fifo_depth_log2+1)-bit counter and zero-extended or saturated to 5 bits. Write: no effect.
  - 3 INPUT: read in_pins after a 2-flop synchroniser; reflects pins with 2–3 cycle latency. Write: no effect.
  - 4 SCRATCH: read/write an 8-bit register.
  - 5 CLEAR: write any value flushes the FIFO (level=0) and clears overflow. test_done/test_fail are unaffected. Read 0.
  - 6, 7: read 0; writes ignored.
- FIFO push/pop rules:
  - Pop occurs when trace_valid & trace_ready.
  - Push is accepted if level < depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - Simultaneous push and pop: level unchanged, data order preserved.
  - Read/write pointers wrap modulo depth.
  - trace_data = mem[rd_ptr], valid whenever trace_valid=1.
- A CLEAR write in the same cycle as a pop: flush wins, level=0.
- io_re and io_we in the same cycle: both serviced. A STATUS read returns the pre-update value.
- end_of_test pulses again on each subsequent pass/fail write; test_done stays 1 until reset.
- Reset mid-operation: all state returns to reset values immediately; the FIFO contents are discarded.

Test Plan:
- Reset, then read STATUS (base+2) -> io_di=8'h20 (empty=1, level 0) one cycle after io_re; io_di=0 the following cycle with no strobe.
- trace_ready=0, write 17 bytes 0x00..0x10 to TXDATA -> STATUS=8'hD0 (overflow, full, level 16), irq=1. Then trace_ready=1 -> stream emits 0x00..0x0F in order, byte 0x10 is lost, trace_valid drops after 16 beats.
- FIFO full, trace_ready=1, write 0xAA in the same cycle as a pop -> accepted, overflow stays 0, level stays 16, 0xAA emitted last.
- Write 0xFE to CTRL -> end_of_test high for exactly 1 cycle, CTRL read=8'h01. Then write 0xFF -> second pulse, CTRL read=8'h03. Write 0x12 -> no pulse.
- in_pins 0x00->0x5A at cycle t -> INPUT read issued at t+3 returns 0x5A; read issued at t returns 0x00. SCRATCH write 0x3C then read -> 0x3C. Strobes at base+8 -> io_di=0, no state change.
- 5 bytes queued with overflow set, write CLEAR -> STATUS=8'h20, irq=0. Assert sys_rst mid-stream -> trace_valid=0 and all outputs at reset values asynchronously.
